caravel_io_ctrl: RTL and testbench
==================================

# caravel_io_ctrl

- Wishbone-controlled pad controller placed between the Caravel user-project pins and the SoC core (`caravel_hack_soc`).
- Parametrised in pad count: `NUM_IO` pads, each individually muxed between core-driven and register-driven output/enable.
- Synchronises all pad inputs and raises a maskable rising-edge interrupt.
- Occupies one address window on the user Wishbone bus; the core keeps its own pins unchanged behind it.

## Interface
Parameters:
- `NUM_IO`, 38, number of pads handled (1..64).
- `BASE_ADDR`, 32'h3000_0000, window base; decode on `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.

Ports:
- `wb_clk_i` in 1: sole clock, all state on rising edge.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic strobes.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data.
- `wbs_ack_o` out 1: acknowledge.
- `io_in` in NUM_IO: pad inputs.
- `io_out` out NUM_IO: pad output values.
- `io_oeb` out NUM_IO: pad output-enable bar.
- `core_io_in` out NUM_IO: unsynchronised passthrough of `io_in` to the core.
- `core_io_out` in NUM_IO: core output values.
- `core_io_oeb` in NUM_IO: core output-enable bars.
- `irq_o` out 1: edge interrupt, level.

## Operation
Register map: offset `adr[7:2]`. Each vector uses two words: LO holds bits 31:0, HI holds bits 63:32.
- 0x00/0x04 SEL: 1 = pad driven from OUT/OEB registers; 0 = pad driven by core. Reset 0.
- 0x08/0x0C OUT: register output values. Reset 0.
- 0x10/0x14 OEB: register enable bars. Reset all ones.
- 0x18/0x1C IN: read-only synchronised pad inputs.
- 0x20/0x24 STAT: rising-edge status; write-1-to-clear. Reset 0.
- 0x28/0x2C IEN: interrupt enable. Reset 0.
- Other offsets in the window: acked, read 0, writes ignored.

Pad muxing and interrupt:
- `io_out[i] = SEL[i] ? OUT[i] : core_io_out[i]`; same structure for `io_oeb` using OEB and `core_io_oeb`. Purely combinational from registers.
- `irq_o = |(STAT & IEN)`, registered-free OR of flop outputs.

Register access rules:
- Writes honour `wbs_sel_i` per byte.
- Bits at index ≥ NUM_IO read 0 and ignore writes.
- Writes to IN are ignored.

Input synchronisation and edge detection:
- Two-flop synchroniser per pad, then a previous-value flop.
- `rise[i] = sync[i] & ~prev[i]`; rise sets `STAT[i]`.
- Edge detection runs regardless of SEL.

Reset values:
- `wbs_ack_o` = 0, `wbs_dat_o` = 0, `irq_o` = 0.
- `io_oeb` = `core_io_oeb`, since SEL = 0.
- Synchroniser and previous-value flops = 0.

## Timing
Wishbone handshake:
- Request valid when `cyc & stb & hit & ~wbs_ack_o`. Ack is a registered one-cycle pulse on the next edge.
- A held request produces at most one ack every two cycles; back-to-back acks never occur.
- `wbs_dat_o` is valid only while ack is high and is 0 otherwise.
- Read data is sampled at the request edge.
- A write commits on the same edge that raises ack; `io_out`/`io_oeb` reflect it from that edge.
- Addresses outside the window never ack.

Input path latency:
- A pad change is visible in IN after 2 edges.
- STAT sets on the 3rd edge; `irq_o` rises in the same cycle as that STAT update.
- A pad held high sets STAT once; it sets again only after a low-to-high transition.

Simultaneous events and reset:
- W1C and a rise on the same bit in the same cycle: the set wins and the bit stays 1.
- Asserting `wb_rst_i` mid-transaction clears ack immediately. The master must reissue the access.

## Test plan
- Reset, then read 0x10 and 0x14 with NUM_IO=38 → 0xFFFF_FFFF and 0x0000_003F. `wbs_ack_o` high exactly one cycle after the request; `io_oeb == core_io_oeb`.
- Write SEL_LO=0x1, OUT_LO=0x1, OEB_LO=0x0 → `io_out[0]=1`, `io_oeb[0]=0` from the write's ack edge. Other pads keep tracking `core_io_*`.
- Write OUT_HI=0xFFFF_FFFF with `wbs_sel_i`=4'b0001 → readback 0x0000_003F. This checks both the byte-enable mask and the NUM_IO mask.
- IEN_LO=0x4, then toggle `io_in[2]` 0→1 → IN_LO bit 2 set after 2 cycles; STAT_LO=0x4 and `irq_o`=1 at the 3rd cycle.
- Write STAT_LO=0x4 on the same cycle a new rise on bit 2 is detected → STAT stays 0x4 and `irq_o` stays 1. A later W1C with no rise clears both.
- Access to BASE_ADDR+0x100 → no ack for 8 cycles. Assert `wb_rst_i` while a request is pending → ack drops asynchronously and all registers return to their reset values.

Source files
------------

// File: rtl/caravel_io_ctrl_if.sv
// Wishbone classic slave bus used by the Caravel pad controller.
// The master modport is the management SoC side, the slave modport is the pad controller.
interface caravel_io_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/caravel_io_ctrl.sv
// Pad controller between the Caravel user pins and the SoC core.
// Each pad is muxed between core-driven and register-driven out/oeb, all pad
// inputs are synchronised, and rising edges raise a maskable level interrupt.
// Registers are split into LO (bits 31:0) and HI (bits 63:32) words; bits at
// index >= NUM_IO do not exist, so they read 0 and swallow writes.
module caravel_io_ctrl #(
    parameter int          NUM_IO    = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    caravel_io_ctrl_if.slave     wb,
    input  logic [NUM_IO-1:0]    io_in,
    output logic [NUM_IO-1:0]    io_out,
    output logic [NUM_IO-1:0]    io_oeb,
    output logic [NUM_IO-1:0]    core_io_in,
    input  logic [NUM_IO-1:0]    core_io_out,
    input  logic [NUM_IO-1:0]    core_io_oeb,
    output logic                 irq_o
);

    // Register pair index (adr[7:3]); adr[2] selects the LO/HI word.
    localparam logic [4:0] REG_SEL  = 5'd0;
    localparam logic [4:0] REG_OUT  = 5'd1;
    localparam logic [4:0] REG_OEB  = 5'd2;
    localparam logic [4:0] REG_IN   = 5'd3;
    localparam logic [4:0] REG_STAT = 5'd4;
    localparam logic [4:0] REG_IEN  = 5'd5;

    logic [NUM_IO-1:0] sel_q;
    logic [NUM_IO-1:0] out_q;
    logic [NUM_IO-1:0] oeb_q;
    logic [NUM_IO-1:0] stat_q;
    logic [NUM_IO-1:0] ien_q;
    logic [NUM_IO-1:0] sync1;
    logic [NUM_IO-1:0] sync2;
    logic [NUM_IO-1:0] prev;
    logic [NUM_IO-1:0] rise;
    logic [NUM_IO-1:0] bit_we;
    logic [NUM_IO-1:0] bit_wd;
    logic [NUM_IO-1:0] stat_clr;
    logic              ack_q;
    logic [31:0]       dat_q;

    logic              hit;
    logic              req;
    logic              wr;
    logic [4:0]        reg_idx;
    logic              hi;
    logic [63:0]       rd_view;
    logic [31:0]       rd_word;

    // Bus decode; ack_q in the request term spaces acks of a held request.
    assign hit     = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
    assign wr      = req & wb.wbs_we_i;
    assign reg_idx = wb.wbs_adr_i[7:3];
    assign hi      = wb.wbs_adr_i[2];

    // Per-pad write strobe and data: pad i lives in word i/32, byte (i%32)/8.
    always_comb begin
        bit_we = '0;
        bit_wd = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            bit_we[i] = (hi == (i >= 32)) && wb.wbs_sel_i[(i % 32) / 8];
            bit_wd[i] = wb.wbs_dat_i[i % 32];
        end
    end

    assign rise     = sync2 & ~prev;
    assign stat_clr = (wr && reg_idx == REG_STAT) ? (bit_we & bit_wd) : '0;

    // Read mux: zero-extended 64-bit view of the addressed pair, then pick a word.
    always_comb begin
        rd_view = '0;
        case (reg_idx)
            REG_SEL:  rd_view[NUM_IO-1:0] = sel_q;
            REG_OUT:  rd_view[NUM_IO-1:0] = out_q;
            REG_OEB:  rd_view[NUM_IO-1:0] = oeb_q;
            REG_IN:   rd_view[NUM_IO-1:0] = sync2;
            REG_STAT: rd_view[NUM_IO-1:0] = stat_q;
            REG_IEN:  rd_view[NUM_IO-1:0] = ien_q;
            default:  rd_view = '0;
        endcase
        rd_word = hi ? rd_view[63:32] : rd_view[31:0];
    end

    // Bus response: single-cycle ack, read data only alongside ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wb.wbs_we_i) ? rd_word : '0;
        end
    end

    // Configuration registers, written on the edge that raises ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_q <= '0;
            out_q <= '0;
            oeb_q <= '1;
            ien_q <= '0;
        end else if (wr) begin
            if (reg_idx == REG_SEL) sel_q <= (sel_q & ~bit_we) | (bit_wd & bit_we);
            if (reg_idx == REG_OUT) out_q <= (out_q & ~bit_we) | (bit_wd & bit_we);
            if (reg_idx == REG_OEB) oeb_q <= (oeb_q & ~bit_we) | (bit_wd & bit_we);
            if (reg_idx == REG_IEN) ien_q <= (ien_q & ~bit_we) | (bit_wd & bit_we);
        end
    end

    // Input synchroniser, previous-value stage and sticky edge status (set beats clear).
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            stat_q <= '0;
        end else begin
            sync1  <= io_in;
            sync2  <= sync1;
            prev   <= sync2;
            stat_q <= (stat_q & ~stat_clr) | rise;
        end
    end

    assign io_out     = (sel_q & out_q) | (~sel_q & core_io_out);
    assign io_oeb     = (sel_q & oeb_q) | (~sel_q & core_io_oeb);
    assign core_io_in = io_in;
    assign irq_o      = |(stat_q & ien_q);

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_caravel_io_ctrl.sv
// Directed bench for caravel_io_ctrl with NUM_IO = 38.
module tb_caravel_io_ctrl;
    localparam int          NIO  = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIO-1:0]  io_in;
    logic [NIO-1:0]  io_out;
    logic [NIO-1:0]  io_oeb;
    logic [NIO-1:0]  core_io_in;
    logic [NIO-1:0]  core_io_out;
    logic [NIO-1:0]  core_io_oeb;
    logic            irq;
    int              n_checks = 0;
    int              n_fail = 0;
    logic [31:0]     rd;
    int              ack_seen;

    caravel_io_ctrl_if wb();

    caravel_io_ctrl #(.NUM_IO(NIO), .BASE_ADDR(BASE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .core_io_in  (core_io_in),
        .core_io_out (core_io_out),
        .core_io_oeb (core_io_oeb),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
    endtask

    task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
    endtask

    // Called #1 after an edge; returns #1 after the edge following the ack.
    task automatic wb_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
        bus_drive(1'b1, BASE + 32'(off), dat, sel);
        @(posedge clk); #1;
        chk("wr_ack", 64'(wb.wbs_ack_o), 64'd1);
        bus_idle();
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] dat);
        bus_drive(1'b0, BASE + 32'(off), 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("rd_ack", 64'(wb.wbs_ack_o), 64'd1);
        dat = wb.wbs_dat_o;
        bus_idle();
        @(posedge clk); #1;
        chk("ack_drop", 64'(wb.wbs_ack_o), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        io_in       = '0;
        core_io_out = 38'h2A_5A5A_1234;
        core_io_oeb = 38'h15_0F0F_F0F0;
        bus_idle();
        #1;
        chk("rst_ack", 64'(wb.wbs_ack_o), 64'd0);
        chk("rst_dat", 64'(wb.wbs_dat_o), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_oeb", 64'(io_oeb), 64'h15_0F0F_F0F0);
        chk("rst_out", 64'(io_out), 64'h2A_5A5A_1234);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        wb_read(8'h10, rd); chk("oeb_lo_rst", 64'(rd), 64'hFFFF_FFFF);
        wb_read(8'h14, rd); chk("oeb_hi_rst", 64'(rd), 64'h0000_003F);
        wb_read(8'h00, rd); chk("sel_lo_rst", 64'(rd), 64'h0);

        // Held request: ack must alternate, never back-to-back.
        bus_drive(1'b0, BASE + 32'h14, 32'h0, 4'hF);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("held_ack", 64'(wb.wbs_ack_o), (c % 2 == 0) ? 64'd1 : 64'd0);
            chk("held_dat", 64'(wb.wbs_dat_o), (c % 2 == 0) ? 64'h3F : 64'h0);
        end
        bus_idle();
        @(posedge clk); #1;

        // Pad 0 taken over by the registers.
        wb_write(8'h00, 32'h1, 4'hF);
        chk("sel_oeb", 64'(io_oeb), 64'h15_0F0F_F0F1);
        chk("sel_out", 64'(io_out), 64'h2A_5A5A_1234);
        bus_drive(1'b1, BASE + 32'h08, 32'h1, 4'hF);
        @(posedge clk); #1;
        chk("out_at_ack", 64'(io_out), 64'h2A_5A5A_1235);
        bus_idle();
        @(posedge clk); #1;
        bus_drive(1'b1, BASE + 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("oeb_at_ack", 64'(io_oeb[0]), 64'd0);
        bus_idle();
        @(posedge clk); #1;
        core_io_oeb = '1;
        core_io_out = '1;
        #1;
        chk("track_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFE);
        chk("track_out", 64'(io_out), 64'h3F_FFFF_FFFF);
        core_io_out = '0;
        #1;
        chk("track_out0", 64'(io_out), 64'h1);

        // Byte-enable and NUM_IO masks on OUT_HI.
        wb_write(8'h0C, 32'hFFFF_FFFF, 4'b0001);
        wb_read(8'h0C, rd); chk("out_hi_mask", 64'(rd), 64'h3F);
        wb_write(8'h0C, 32'h0, 4'b1110);
        wb_read(8'h0C, rd); chk("out_hi_bsel", 64'(rd), 64'h3F);
        chk("out_hi_unsel", 64'(io_out), 64'h1);
        wb_write(8'h08, 32'hFFFF_0000, 4'b0100);
        wb_read(8'h08, rd); chk("out_lo_byte2", 64'(rd), 64'h00FF_0001);

        // IN is read-only; unmapped offsets read 0.
        wb_write(8'h18, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h18, rd); chk("in_ro", 64'(rd), 64'h0);
        wb_write(8'h30, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h30, rd); chk("unmapped", 64'(rd), 64'h0);
        chk("core_in", 64'(core_io_in), 64'h0);

        // Rising edge on pad 2: irq exactly 3 edges after the pad change.
        wb_write(8'h28, 32'h4, 4'hF);
        io_in[2] = 1'b1;
        #1 chk("core_in_pass", 64'(core_io_in), 64'h4);
        @(posedge clk);
        @(posedge clk); #1;
        chk("irq_early", 64'(irq), 64'd0);
        @(posedge clk); #1;
        chk("irq_rise", 64'(irq), 64'd1);
        wb_read(8'h18, rd); chk("in_lo", 64'(rd), 64'h4);
        wb_read(8'h20, rd); chk("stat_lo", 64'(rd), 64'h4);

        // W1C while a fresh rise lands on the same edge: set wins.
        io_in[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        io_in[2] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        wb_write(8'h20, 32'h4, 4'hF);
        chk("irq_collide", 64'(irq), 64'd1);
        wb_read(8'h20, rd); chk("stat_collide", 64'(rd), 64'h4);
        wb_write(8'h20, 32'h4, 4'hF);
        chk("irq_clear", 64'(irq), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        wb_read(8'h20, rd); chk("stat_held_hi", 64'(rd), 64'h0);

        // Outside the window: never acked.
        ack_seen = 0;
        bus_drive(1'b0, BASE + 32'h100, 32'h0, 4'hF);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) ack_seen++;
        end
        bus_idle();
        chk("no_ack_oow", 64'(ack_seen), 64'd0);

        // Reset while an ack is outstanding.
        io_in[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1 io_in[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("irq_pre_rst", 64'(irq), 64'd1);
        bus_drive(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("ack_pre_rst", 64'(wb.wbs_ack_o), 64'd1);
        rst   = 1'b1;
        io_in = '0;
        #1;
        chk("ack_async", 64'(wb.wbs_ack_o), 64'd0);
        chk("irq_async", 64'(irq), 64'd0);
        chk("out_async", 64'(io_out), 64'h0);
        chk("oeb_async", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        bus_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(8'h00, rd); chk("sel_after", 64'(rd), 64'h0);
        wb_read(8'h08, rd); chk("out_after", 64'(rd), 64'h0);
        wb_read(8'h10, rd); chk("oeb_after", 64'(rd), 64'hFFFF_FFFF);
        wb_read(8'h28, rd); chk("ien_after", 64'(rd), 64'h0);
        wb_read(8'h20, rd); chk("stat_after", 64'(rd), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
